// File: rtl/up_down_cmd_gen.sv
// up_down_cmd_gen
// Command-side master for an up/down counter. Accepts a target value over a
// valid/ready handshake, then drives the counter's load/up/down inputs until
// the counter output equals the target. A far target is reached with one
// load. A near target is reached with single steps.
//
// Ports:
//   i_clk, i_rst          clock (rising edge), async active-high reset
//   i_req_valid/o_req_ready/i_req_target   request handshake and target value
//   i_abort               cancel the request in progress (ignored in IDLE)
//   i_cnt_value/high/low  counter observation: value, all-ones flag, zero flag
//   o_load/o_in/o_up/o_down  commands to the counter (o_in is always target_r)
//   o_busy/o_done/o_err   status: not idle, reached pulse, stall/saturation pulse
//   o_steps               commands issued for the current/last request (saturating)
module up_down_cmd_gen #(
  parameter int DATA_WIDTH     = 5,
  parameter int LOAD_THRESHOLD = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [DATA_WIDTH-1:0] i_req_target,
  input  logic                  i_abort,
  input  logic [DATA_WIDTH-1:0] i_cnt_value,
  input  logic                  i_cnt_high,
  input  logic                  i_cnt_low,
  output logic                  o_load,
  output logic [DATA_WIDTH-1:0] o_in,
  output logic                  o_up,
  output logic                  o_down,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [DATA_WIDTH-1:0] o_steps
);

  typedef enum logic [2:0] {
    S_IDLE, S_EVAL, S_LOAD, S_UP, S_DOWN, S_WAIT, S_DONE, S_ERR
  } state_e;

  localparam int unsigned THR = LOAD_THRESHOLD;
  localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] target_q, target_d;
  logic [DATA_WIDTH-1:0] snap_q, snap_d;
  logic [DATA_WIDTH-1:0] steps_q, steps_d;

  logic [DATA_WIDTH:0]   diff;
  logic                  tgt_gt;
  logic                  cmd_load, cmd_up, cmd_down;

  // Step commands are withheld when the counter is already pinned, so a wrap
  // is never requested.
  assign cmd_load = (state_q == S_LOAD);
  assign cmd_up   = (state_q == S_UP)   && !i_cnt_high;
  assign cmd_down = (state_q == S_DOWN) && !i_cnt_low;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    snap_d   = snap_q;
    steps_d  = steps_q;

    tgt_gt = (target_q > i_cnt_value);
    if (tgt_gt) diff = {1'b0, target_q} - {1'b0, i_cnt_value};
    else        diff = {1'b0, i_cnt_value} - {1'b0, target_q};

    if ((cmd_load || cmd_up || cmd_down) && (steps_q != {DATA_WIDTH{1'b1}}))
      steps_d = steps_q + ONE;

    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          target_d = i_req_target;
          steps_d  = '0;
          state_d  = S_EVAL;
        end
      end
      S_EVAL: begin
        // Snapshot lets WAIT tell whether the counter actually moved.
        snap_d = i_cnt_value;
        if (diff == '0)                 state_d = S_DONE;
        else if (32'(diff) > THR)       state_d = S_LOAD;
        else if (tgt_gt)                state_d = S_UP;
        else                            state_d = S_DOWN;
      end
      S_LOAD: state_d = S_WAIT;
      S_UP:   state_d = i_cnt_high ? S_ERR : S_WAIT;
      S_DOWN: state_d = i_cnt_low  ? S_ERR : S_WAIT;
      S_WAIT: state_d = (i_cnt_value == snap_q) ? S_ERR : S_EVAL;
      S_DONE: state_d = S_IDLE;
      S_ERR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over every transition except acceptance in IDLE.
    if (i_abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      target_q <= '0;
      snap_q   <= '0;
      steps_q  <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      snap_q   <= snap_d;
      steps_q  <= steps_d;
    end
  end

  assign o_req_ready = (state_q == S_IDLE);
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = (state_q == S_DONE);
  assign o_err       = (state_q == S_ERR);
  assign o_load      = cmd_load;
  assign o_up        = cmd_up;
  assign o_down      = cmd_down;
  assign o_in        = target_q;
  assign o_steps     = steps_q;

endmodule

// File: tb/tb_up_down_cmd_gen.sv
module tb_up_down_cmd_gen;
  localparam int DW  = 5;
  localparam int THR = 8;

  logic          i_clk = 0, i_rst = 1;
  logic          i_req_valid = 0, i_abort = 0;
  logic [DW-1:0] i_req_target = '0;
  logic          o_req_ready, o_load, o_up, o_down, o_busy, o_done, o_err;
  logic [DW-1:0] o_in, o_steps;

  // Behavioural counter environment
  logic [DW-1:0] cnt = '0;
  logic          freeze = 0, force_en = 0;
  logic [DW-1:0] force_val = '0;
  wire           cnt_high = (cnt == 5'd31);
  wire           cnt_low  = (cnt == 5'd0);

  int checks = 0, fails = 0;

  up_down_cmd_gen #(.DATA_WIDTH(DW), .LOAD_THRESHOLD(THR)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_target(i_req_target), .i_abort(i_abort), .i_cnt_value(cnt),
    .i_cnt_high(cnt_high), .i_cnt_low(cnt_low), .o_load(o_load), .o_in(o_in),
    .o_up(o_up), .o_down(o_down), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_steps(o_steps));

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (force_en) cnt <= force_val;
    else if (!freeze) begin
      if (o_load)      cnt <= o_in;
      else if (o_up)   cnt <= cnt + 5'd1;
      else if (o_down) cnt <= cnt - 5'd1;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_cnt(input logic [DW-1:0] v);
    @(negedge i_clk);
    force_en = 1; force_val = v;
    @(negedge i_clk);
    force_en = 0;
  endtask

  // Issues a request at the current negedge, then samples each following cycle
  // (k=1 is the cycle after acceptance) until done/err or return to idle.
  task automatic run_req(input logic [DW-1:0] tgt, input int abort_at,
                         output int done_c, output int err_c, output int nu,
                         output int nd, output int nl, output int load_in,
                         output logic [63:0] upm);
    bit fin = 0;
    done_c = -1; err_c = -1; nu = 0; nd = 0; nl = 0; load_in = -1; upm = '0;
    i_req_valid = 1; i_req_target = tgt;
    for (int k = 1; k <= 60; k++) begin
      @(negedge i_clk);
      i_req_valid = 0; i_abort = 0;
      if (o_up)   begin nu++; upm[k] = 1'b1; end
      if (o_down) nd++;
      if (o_load) begin nl++; load_in = int'(o_in); end
      if (o_done) done_c = k;
      if (o_err)  err_c = k;
      if (k == abort_at) i_abort = 1;
      if (o_done || o_err || !o_busy) begin fin = 1; break; end
    end
    i_abort = 0;
    chk("terminated_in_budget", int'(fin), 1);
  endtask

  initial begin
    int dc, ec, nu, nd, nl, li, d, en;
    logic [63:0] upm;
    logic [DW-1:0] v, t;

    // Reset state
    #2;
    chk("rst_ready", o_req_ready, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_cmds", {o_load, o_up, o_down, o_done, o_err}, 0);
    chk("rst_in", o_in, 0);
    chk("rst_steps", o_steps, 0);
    @(negedge i_clk); i_rst = 0;

    // Step up 3 -> 5
    set_cnt(5'd3);
    run_req(5'd5, -1, dc, ec, nu, nd, nl, li, upm);
    chk("up_done_cyc", dc, 8);
    chk("up_pulse_cycles", int'(upm[31:0]), (1 << 2) | (1 << 5));
    chk("up_err", ec, -1);
    chk("up_cnt", cnt, 5);
    chk("up_steps", o_steps, 2);

    // Load path 2 -> 30
    set_cnt(5'd2);
    run_req(5'd30, -1, dc, ec, nu, nd, nl, li, upm);
    chk("ld_nload", nl, 1);
    chk("ld_in", li, 30);
    chk("ld_steps_cmds", nu + nd, 0);
    chk("ld_done_cyc", dc, 5);
    chk("ld_steps", o_steps, 1);
    chk("ld_cnt", cnt, 30);

    // Already equal
    set_cnt(5'd17);
    run_req(5'd17, -1, dc, ec, nu, nd, nl, li, upm);
    chk("eq_done_cyc", dc, 2);
    chk("eq_steps", o_steps, 0);
    chk("eq_cmds", nu + nd + nl, 0);

    // Stall: counter frozen at 7
    set_cnt(5'd7);
    freeze = 1;
    run_req(5'd10, -1, dc, ec, nu, nd, nl, li, upm);
    chk("stall_nup", nu, 1);
    chk("stall_err_cyc", ec, 4);
    chk("stall_done", dc, -1);
    chk("stall_steps", o_steps, 1);
    @(negedge i_clk);
    chk("stall_ready", o_req_ready, 1);
    freeze = 0;

    // Saturation guard: value jumps to 31 while the FSM enters UP
    set_cnt(5'd29);
    i_req_valid = 1; i_req_target = 5'd30;
    @(negedge i_clk);                       // EVAL, sees 29 -> UP
    i_req_valid = 0; force_en = 1; force_val = 5'd31;
    @(negedge i_clk);                       // UP with counter at 31
    force_en = 0;
    chk("sat_no_up", o_up, 0);
    chk("sat_busy", o_busy, 1);
    @(negedge i_clk);
    chk("sat_err", o_err, 1);
    chk("sat_cnt", cnt, 31);
    @(negedge i_clk);
    chk("sat_ready", o_req_ready, 1);

    // Abort during the first UP cycle
    set_cnt(5'd0);
    run_req(5'd6, 2, dc, ec, nu, nd, nl, li, upm);
    chk("ab_done", dc, -1);
    chk("ab_err", ec, -1);
    chk("ab_nup", nu, 1);
    chk("ab_ready", o_req_ready, 1);
    chk("ab_cnt", cnt, 1);

    // Reset in WAIT
    set_cnt(5'd0);
    i_req_valid = 1; i_req_target = 5'd6;
    @(negedge i_clk); i_req_valid = 0;      // EVAL
    @(negedge i_clk);                       // UP
    @(negedge i_clk);                       // WAIT
    chk("rw_busy_before", o_busy, 1);
    i_rst = 1; #1;
    chk("rw_ready", o_req_ready, 1);
    chk("rw_busy", o_busy, 0);
    chk("rw_cmds", {o_load, o_up, o_down, o_done, o_err}, 0);
    chk("rw_in", o_in, 0);
    chk("rw_steps", o_steps, 0);
    @(negedge i_clk); i_rst = 0;

    // Randomized requests against the distance-based reference
    for (int it = 0; it < 30; it++) begin
      v = 5'($urandom_range(0, 31));
      t = 5'($urandom_range(0, 31));
      set_cnt(v);
      run_req(t, -1, dc, ec, nu, nd, nl, li, upm);
      d  = (int'(t) > int'(v)) ? int'(t) - int'(v) : int'(v) - int'(t);
      en = (d == 0) ? 0 : (d > THR ? 1 : d);
      chk("rnd_done_cyc", dc, 2 + 3 * en);
      chk("rnd_err", ec, -1);
      chk("rnd_cnt", cnt, int'(t));
      chk("rnd_steps", o_steps, en);
      chk("rnd_nload", nl, (d > THR) ? 1 : 0);
      chk("rnd_nup", nu, (d <= THR && t > v) ? d : 0);
      chk("rnd_ndown", nd, (d <= THR && t < v) ? d : 0);
      @(negedge i_clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/up_down_cmd_gen.md
Name: up_down_cmd_gen

Overview:
- Command-side master for the up/down counter: accepts a target value through a valid/ready request and drives the counter's load/up/down inputs until the counter output equals the target.
- Uses a direct load when the target is far from the current value and single steps when it is near.
- Monitors the counter's value and high/low flags to detect completion and stalls.
- Sits between control logic and the counter instance. Its command outputs connect directly to the counter's load, in, up and down inputs.

Parameters:
- DATA_WIDTH, 5, width of target, counter value and command data.
- LOAD_THRESHOLD, 8, maximum absolute distance resolved by stepping. A larger distance uses a load. 0 means always load when the value differs from the target.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_req_valid  input  1  request valid.
- o_req_ready  output  1  high only in IDLE.
- i_req_target  input  DATA_WIDTH  requested final counter value.
- i_abort  input  1  cancel the request in progress.
- i_cnt_value  input  DATA_WIDTH  counter's current output.
- i_cnt_high  input  1  counter at all-ones.
- i_cnt_low  input  1  counter at zero.
- o_load  output  1  load command to counter.
- o_in  output  DATA_WIDTH  load data, equal to the captured target.
- o_up  output  1  increment command.
- o_down  output  1  decrement command.
- o_busy  output  1  high in any state other than IDLE.
- o_done  output  1  one-cycle pulse: target reached.
- o_err  output  1  one-cycle pulse: counter failed to move, or was blocked by saturation.
- o_steps  output  DATA_WIDTH  commands issued for the current or last request; saturates at all-ones.

Behaviour:
- Reset: state IDLE, target_r=0, snap_r=0, o_steps=0.
  - All command outputs and o_done, o_err, o_busy are 0. o_in=0. o_req_ready=1.
  - Reset mid-operation aborts immediately; no done or err pulse is produced.
- Command and status outputs are decoded from registered state (Moore). They are glitch-free and each is asserted for exactly one cycle per issue.
- IDLE: when i_req_valid and o_req_ready are both high at a clock edge:
  - target_r is set to i_req_target.
  - o_steps is cleared.
  - The state moves to EVAL.
- EVAL (no command driven): compute diff = |target_r - i_cnt_value| in DATA_WIDTH+1 bits.
  - diff=0: go to DONE.
  - diff > LOAD_THRESHOLD: go to LOAD.
  - Otherwise, target greater than value: go to UP; target less than value: go to DOWN.
  - snap_r is set to i_cnt_value on every EVAL exit.
- LOAD: o_load=1 and o_in=target_r for one cycle, then go to WAIT.
- UP: if i_cnt_high is set, go to ERR with o_up=0. Otherwise o_up=1 for one cycle, then go to WAIT.
- DOWN: if i_cnt_low is set, go to ERR with o_down=0. Otherwise o_down=1 for one cycle, then go to WAIT.
- o_steps increments on each cycle in LOAD, UP or DOWN that actually asserts a command.
- WAIT: the counter has registered the command at the previous edge.
  - i_cnt_value equal to snap_r: go to ERR (stall).
  - Otherwise go to EVAL.
- DONE: o_done=1 for one cycle, then go to IDLE. ERR: o_err=1 for one cycle, then go to IDLE.
- Step cadence: 3 cycles per step (cmd, WAIT, EVAL). A load costs 3 cycles plus the final EVAL.
- Abort:
  - i_abort high in any non-IDLE state forces IDLE at the next edge. No done or err pulse is produced.
  - A command already being driven in that cycle still reaches the counter.
  - i_abort is ignored in IDLE. Simultaneous i_req_valid and i_abort in IDLE: the request is accepted.
- Arithmetic: no wrap-around is ever commanded. Up is never issued at all-ones; down is never issued at zero.
- o_in holds target_r at all times. The counter ignores it unless o_load is high.

Test Plan:
- Step up: reset, counter=3, request target=5 with LOAD_THRESHOLD=8.
  - Required: accept at c0, then o_up pulses at c2 and c5.
  - o_done pulses at c8, counter=5, o_steps=2, o_err never set.
- Load path: counter=2, request target=30.
  - Required: a single o_load pulse with o_in=30, then EVAL finds a match.
  - o_done pulses, o_steps=1, no up or down pulses.
- Already equal: counter=17, request target=17.
  - Required: o_done pulses 2 cycles after accept, o_steps=0, no commands issued.
- Stall: counter frozen at 7 by the bench, request target=10.
  - Required: one o_up, then WAIT sees 7 and o_err pulses.
  - Returns to IDLE with o_req_ready=1 and o_steps=1.
- Saturation guard: value forced to 31 with i_cnt_high=1 while the FSM is entering UP.
  - Required: o_up is never asserted and o_err pulses.
- Abort and reset: counter=0, target=6.
  - Abort after the first o_up: next cycle in IDLE, no o_done, counter=1.
  - Repeat and assert i_rst mid-WAIT: all outputs return to reset values asynchronously.
